// File: rtl/spi_master_ctrl_pkg.sv
// Shared definitions for the SPI master: command mode encodings (shared with the
// decoder), FSM state encodings and a small helper used by the controller.
package spi_master_ctrl_pkg;

    localparam int W_SPI_MODE  = 2;
    localparam int W_SPI_STATE = 3;

    typedef enum logic [W_SPI_MODE-1:0] {
        SPI_IDLE    = 2'b00,
        SPI_SEND    = 2'b01,
        SPI_RECEIVE = 2'b10,
        SPI_XFER    = 2'b11
    } spi_mode_e;

    typedef enum logic [W_SPI_STATE-1:0] {
        SPI_ST_IDLE  = 3'd0,
        SPI_ST_SETUP = 3'd1,
        SPI_ST_SHIFT = 3'd2,
        SPI_ST_HOLD  = 3'd3,
        SPI_ST_DONE  = 3'd4
    } spi_state_e;

    function automatic logic mode_receives(input logic [W_SPI_MODE-1:0] mode);
        return (mode == SPI_RECEIVE) || (mode == SPI_XFER);
    endfunction

endpackage

// File: rtl/spi_master_ctrl_clk_div.sv
// Divider for the SPI master: counts CLK_DIV cycles per phase and, while shifting,
// tracks the sclk half-period to emit rise/fall strobes and the sclk level.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic shift_en,
    output logic rise_stb,
    output logic fall_stb,
    output logic phase_end,
    output logic sclk_level
);

    localparam int             CW   = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          half_q, half_d;

    // half_q = 0 is the high half of a bit; it only toggles while shifting.
    always_comb begin
        cnt_d     = cnt_q;
        half_d    = half_q;
        phase_end = en && (cnt_q == LAST);
        if (!en) begin
            cnt_d  = '0;
            half_d = 1'b0;
        end else if (phase_end) begin
            cnt_d = '0;
            if (shift_en) begin
                half_d = ~half_q;
            end
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign sclk_level = shift_en && !half_q;
    assign rise_stb   = sclk_level && (cnt_q == '0);
    assign fall_stb   = sclk_level && phase_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            half_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            half_q <= half_d;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// Single-byte SPI mode-0 master sequenced for the CPU. Optional feature macro:
// SPI_LOOPBACK_EN adds a 'loopback' input that feeds mosi back as the shift-in source.
module spi_master_ctrl
    import spi_master_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W_SPI_MODE-1:0] spi_mode,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [7:0]            tx_data,
    output logic [7:0]            rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
`ifdef SPI_LOOPBACK_EN
    input  logic                  loopback,
`endif
    output logic                  cs_n
);

    spi_state_e            state_q, state_d;
    logic [W_SPI_MODE-1:0] mode_q, mode_d;
    logic [7:0]            tx_shift_q, tx_shift_d;
    logic [7:0]            rx_shift_q, rx_shift_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;

    logic active, shifting, shift_in;
    logic rise_stb, fall_stb, phase_end, sclk_level;

    assign active   = (state_q == SPI_ST_SETUP) || (state_q == SPI_ST_SHIFT) ||
                      (state_q == SPI_ST_HOLD);
    assign shifting = (state_q == SPI_ST_SHIFT);

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk        (clk),
        .rst        (rst),
        .en         (active),
        .shift_en   (shifting),
        .rise_stb   (rise_stb),
        .fall_stb   (fall_stb),
        .phase_end  (phase_end),
        .sclk_level (sclk_level)
    );

    assign cmd_ready = (state_q == SPI_ST_IDLE);
    assign busy      = (state_q != SPI_ST_IDLE);
    assign cs_n      = !active;
    assign sclk      = sclk_level;
    assign mosi      = active && tx_shift_q[7];
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;

`ifdef SPI_LOOPBACK_EN
    assign shift_in = loopback ? mosi : miso;
`else
    assign shift_in = miso;
`endif

    // rx_data/rx_valid are loaded on the HOLD->DONE edge so they are visible during DONE.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        bit_cnt_d  = bit_cnt_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        case (state_q)
            SPI_ST_IDLE: begin
                if (cmd_valid && (spi_mode != SPI_IDLE)) begin
                    mode_d     = spi_mode;
                    tx_shift_d = (spi_mode == SPI_RECEIVE) ? 8'h00 : tx_data;
                    rx_shift_d = 8'h00;
                    bit_cnt_d  = 3'd7;
                    state_d    = SPI_ST_SETUP;
                end
            end
            SPI_ST_SETUP: begin
                if (phase_end) begin
                    state_d = SPI_ST_SHIFT;
                end
            end
            SPI_ST_SHIFT: begin
                if (rise_stb) begin
                    rx_shift_d = {rx_shift_q[6:0], shift_in};
                end
                if (fall_stb) begin
                    tx_shift_d = {tx_shift_q[6:0], 1'b0};
                end
                if (phase_end && !sclk_level) begin
                    if (bit_cnt_q == 3'd0) begin
                        state_d = SPI_ST_HOLD;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end
                end
            end
            SPI_ST_HOLD: begin
                if (phase_end) begin
                    state_d = SPI_ST_DONE;
                    if (mode_receives(mode_q)) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                    end
                end
            end
            SPI_ST_DONE: begin
                state_d = SPI_ST_IDLE;
            end
            default: begin
                state_d = SPI_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= SPI_ST_IDLE;
            mode_q     <= SPI_IDLE;
            tx_shift_q <= 8'h00;
            rx_shift_q <= 8'h00;
            bit_cnt_q  <= 3'd0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

endmodule
